param_twisted_ring_counter: RTL and testbench

//  Parametrised successor to the fixed 6-bit Johnson counter: WIDTH-bit shift counter selectable
//  at run time between Johnson (twisted-ring, 2*WIDTH states) and ring (one-hot, WIDTH states).

---
 rtl/param_twisted_ring_counter.sv | 130 +++++++++++++
 tb/tb_param_twisted_ring_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/param_twisted_ring_counter.sv
// -----------------------------------------------------------------------------
// param_twisted_ring_counter
//
// WIDTH-bit shift counter that runs either as a Johnson (twisted-ring) counter
// with 2*WIDTH states or as a one-hot ring counter with WIDTH states. It counts
// up or down, supports a synchronous parallel load, and corrects itself when
// it finds an illegal state. The phase output decodes the counter into a
// sequence index. The wrap and err outputs are registered single-cycle pulses.
//
// Ports
//   clk      in   1      rising-edge clock
//   clear    in   1      asynchronous active-low reset
//   en       in   1      count enable (one shift per edge)
//   dir      in   1      0 = up (toward MSB), 1 = down (toward LSB)
//   mode     in   1      0 = Johnson, 1 = ring
//   load     in   1      synchronous parallel load, has priority over en
//   load_val in   WIDTH  value loaded into count
//   count    out  WIDTH  counter register
//   phase    out  PW     combinational decode of count (0 when count is illegal)
//   wrap     out  1      pulse after a legal step across the PMAX/0 boundary
//   err      out  1      pulse after an illegal-state correction
// -----------------------------------------------------------------------------
module param_twisted_ring_counter #(
  parameter int WIDTH = 6,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  logic             w_legal_j;
  logic             w_legal_r;
  logic             w_legal;
  logic [PW-1:0]    w_phase;
  logic [PW-1:0]    w_pmax;
  logic             w_wrap_step;
  logic [WIDTH-1:0] w_next;

  // Johnson: a ring of 1s and a ring of 0s start at the LSB. This is the
  // 0*1* pattern (adding 1 clears every set bit) or the 1*0* pattern (the
  // same test applied to the complement).
  // Ring: exactly one bit is set.
  function automatic logic f_legal_j(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
  endfunction

  function automatic logic f_legal_r(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Decode a legal value. In Johnson mode with the MSB set, WIDTH + zeros
  // equals 2*WIDTH - ones.
  function automatic logic [PW-1:0] f_phase(input logic [WIDTH-1:0] v,
                                            input logic ring);
    int n;
    n = 0;
    if (ring) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) n = i;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) n = n + 1;
      if (v[WIDTH-1]) n = 2*WIDTH - n;
    end
    return PW'(n);
  endfunction

  assign w_legal_j = f_legal_j(r_count);
  assign w_legal_r = f_legal_r(r_count);
  assign w_legal   = mode ? w_legal_r : w_legal_j;
  assign w_phase   = w_legal ? f_phase(r_count, mode) : '0;
  assign w_pmax    = mode ? PW'(WIDTH-1) : PW'(2*WIDTH-1);

  // Wrap fires only on a legal step that crosses the end of the sequence.
  assign w_wrap_step = w_legal && (dir ? (w_phase == '0) : (w_phase == w_pmax));

  always_comb begin
    w_next = r_count;
    if (!w_legal) begin
      w_next = mode ? WIDTH'(1) : '0;
    end else begin
      case ({mode, dir})
        2'b00:   w_next = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
        2'b01:   w_next = {~r_count[0], r_count[WIDTH-1:1]};
        2'b10:   w_next = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
        default: w_next = {r_count[0], r_count[WIDTH-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_count <= load_val;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_count <= w_next;
      r_wrap  <= w_wrap_step;
      r_err   <= !w_legal;
    end else begin
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign count = r_count;
  assign phase = w_phase;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_param_twisted_ring_counter.sv
module tb_param_twisted_ring_counter;

  localparam int W  = 6;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          clear;
  logic          en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic [PW-1:0] phase;
  logic          wrap, err;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  param_twisted_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .count(count), .phase(phase), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // Reference sequences: the index of a value in its table is its phase.
  logic [W-1:0] jseq [2*W];
  logic [W-1:0] rseq [W];

  initial begin
    for (int k = 0; k < 2*W; k++) begin
      if (k <= W) jseq[k] = W'((1 << k) - 1);
      else        jseq[k] = W'(~((1 << (k - W)) - 1));
    end
    for (int k = 0; k < W; k++) rseq[k] = W'(1 << k);
  end

  function automatic int find_idx(input logic m, input logic [W-1:0] v);
    if (m) begin
      for (int k = 0; k < W; k++) if (rseq[k] == v) return k;
    end else begin
      for (int k = 0; k < 2*W; k++) if (jseq[k] == v) return k;
    end
    return -1;
  endfunction

  // Behavioural model
  logic [W-1:0] m_count;
  logic         m_wrap, m_err;

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      m_count <= '0; m_wrap <= 1'b0; m_err <= 1'b0;
    end else if (load) begin
      m_count <= load_val; m_wrap <= 1'b0; m_err <= 1'b0;
    end else if (en) begin
      int idx, nst;
      idx = find_idx(mode, m_count);
      nst = mode ? W : 2*W;
      if (idx < 0) begin
        m_count <= mode ? W'(1) : W'(0);
        m_err   <= 1'b1;
        m_wrap  <= 1'b0;
      end else begin
        m_count <= mode ? rseq[(idx + (dir ? nst-1 : 1)) % nst]
                        : jseq[(idx + (dir ? nst-1 : 1)) % nst];
        m_wrap  <= dir ? (idx == 0) : (idx == nst-1);
        m_err   <= 1'b0;
      end
    end else begin
      m_wrap <= 1'b0; m_err <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (check_en) begin
      int idx;
      idx = find_idx(mode, m_count);
      chk("model count", 32'(count), 32'(m_count));
      chk("model phase", 32'(phase), (idx < 0) ? 32'd0 : 32'(idx));
      chk("model wrap",  32'(wrap),  32'(m_wrap));
      chk("model err",   32'(err),   32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [W-1:0] t1_exp [12];

  initial begin
    t1_exp = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111,
               6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000};
    clear = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    step(2);
    chk("reset count", 32'(count), 32'd0);
    chk("reset wrap",  32'(wrap),  32'd0);
    chk("reset err",   32'(err),   32'd0);
    chk("reset phase", 32'(phase), 32'd0);
    check_en = 1'b1;
    clear = 1'b1;

    // T1: Johnson up, full cycle
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("T1 count", 32'(count), 32'(t1_exp[i]));
      chk("T1 phase", 32'(phase), (i == 11) ? 32'd0 : 32'(i + 1));
      chk("T1 wrap",  32'(wrap),  (i == 11) ? 32'd1 : 32'd0);
    end

    // T2: Johnson down from zero
    dir = 1'b1;
    step(1);
    chk("T2 count", 32'(count), 32'b100000);
    chk("T2 phase", 32'(phase), 32'd11);
    chk("T2 wrap",  32'(wrap),  32'd1);
    step(1);
    chk("T2 count2", 32'(count), 32'b110000);
    chk("T2 phase2", 32'(phase), 32'd10);
    chk("T2 wrap2",  32'(wrap),  32'd0);

    // T3: ring mode after reset
    en = 1'b0; dir = 1'b0;
    clear = 1'b0;
    step(1);
    clear = 1'b1; mode = 1'b1; en = 1'b1;
    step(1);
    chk("T3 corr count", 32'(count), 32'b000001);
    chk("T3 corr err",   32'(err),   32'd1);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("T3 count", 32'(count), 32'(1 << k));
      chk("T3 phase", 32'(phase), 32'(k));
      chk("T3 err",   32'(err),   32'd0);
    end
    step(1);
    chk("T3 wrap count", 32'(count), 32'b000001);
    chk("T3 wrap",       32'(wrap),  32'd1);
    chk("T3 wrap err",   32'(err),   32'd0);

    // Ring down wrap
    dir = 1'b1;
    step(1);
    chk("ring dn count", 32'(count), 32'b100000);
    chk("ring dn wrap",  32'(wrap),  32'd1);
    dir = 1'b0;

    // T4: illegal load in Johnson mode, then correction
    mode = 1'b0; en = 1'b0; load = 1'b1; load_val = 6'b010100;
    step(1);
    chk("T4 count", 32'(count), 32'b010100);
    chk("T4 phase", 32'(phase), 32'd0);
    load = 1'b0; en = 1'b1;
    step(1);
    chk("T4 corr count", 32'(count), 32'd0);
    chk("T4 corr err",   32'(err),   32'd1);

    // T5: load beats enable, then hold
    load = 1'b1; load_val = 6'b000111;
    step(1);
    chk("T5 count", 32'(count), 32'b000111);
    chk("T5 phase", 32'(phase), 32'd3);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("T5 hold", 32'(count), 32'b000111);
      chk("T5 wrap", 32'(wrap),  32'd0);
      chk("T5 err",  32'(err),   32'd0);
    end

    // T6: async clear between edges
    load = 1'b1; load_val = 6'b001111;
    step(1);
    load = 1'b0; en = 1'b1;
    #1 clear = 1'b0;
    #1;
    chk("T6 async count", 32'(count), 32'd0);
    chk("T6 async wrap",  32'(wrap),  32'd0);
    chk("T6 async err",   32'(err),   32'd0);
    step(1);
    chk("T6 held", 32'(count), 32'd0);
    clear = 1'b1;
    step(1);
    chk("T6 resume", 32'(count), 32'b000001);

    // Mixed mode/dir/enable run, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      en       = (i % 5) != 4;
      dir      = ((i / 7) % 2) == 1;
      mode     = ((i / 13) % 2) == 1;
      load     = (i == 20) || (i == 33);
      load_val = (i == 20) ? 6'b011000 : 6'b111000;
      step(1);
    end
    load = 1'b0;
    step(1);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
